// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode and CSR encodings,
// FSM states and the next-pattern rule.
package led_seq_pkg;

  localparam int unsigned PAT_W = 8;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [1:0] CSR_CTRL    = 2'd0;
  localparam logic [1:0] CSR_PERIOD  = 2'd1;
  localparam logic [1:0] CSR_PATTERN = 2'd2;
  localparam logic [1:0] CSR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic             dir;
  } pat_step_t;

  // Bounce reverses at the end bit and moves one step the other way in the same tick.
  function automatic pat_step_t next_pattern(input logic [PAT_W-1:0] p,
                                             input logic [1:0]       mode,
                                             input logic             dir);
    pat_step_t r;
    r.pattern = p;
    r.dir     = dir;
    case (mode)
      MODE_ROTATE: r.pattern = {p[PAT_W-2:0], p[PAT_W-1]};
      MODE_BOUNCE: begin
        if (!dir) begin
          if (p[PAT_W-1]) begin
            r.dir     = 1'b1;
            r.pattern = {1'b0, p[PAT_W-1:1]};
          end else begin
            r.pattern = {p[PAT_W-2:0], 1'b0};
          end
        end else begin
          if (p[0]) begin
            r.dir     = 1'b0;
            r.pattern = {p[PAT_W-2:0], 1'b0};
          end else begin
            r.pattern = {1'b0, p[PAT_W-1:1]};
          end
        end
      end
      MODE_BLINK: r.pattern = ~p;
      default:    r.pattern = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Tick prescaler: down-counter that fires for one cycle at zero and reloads.
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int unsigned          PERIOD_W    = 24,
  parameter logic [PERIOD_W-1:0]  RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_value,
  input  logic                en,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_r;

  assign tick = en && (count_r == '0);

  // Count register: explicit load beats the terminal-count reload.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= RESET_VALUE;
    end else if (load || tick) begin
      count_r <= load_value;
    end else if (en) begin
      count_r <= count_r - PERIOD_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED animator: CSR slave for configuration plus an Avalon-MM
// master that pushes each new pattern into the PIO data register.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned         LED_W          = 8,
  parameter int unsigned         PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(24'd12499999),
  parameter logic [1:0]          PIO_ADDR       = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  seq_state_e          state_r, state_s;
  logic                enable_r;
  logic [1:0]          mode_r;
  logic [PERIOD_W-1:0] period_r, load_value_s;
  logic [LED_W-1:0]    pattern_r, pattern_s;
  logic                dir_r, dir_s, pending_r, pending_s, stale_r, stale_s;
  logic                m_chipselect_r, m_write_n_r;
  logic [31:0]         m_writedata_r;
  logic                wr_s, ctrl_wr_s, period_wr_s, pattern_wr_s;
  logic                tick_s, reload_s, adv_s, xfer_done_s, enter_write_s;
  pat_step_t           step_s;
  logic                unused_wdata_s;

  assign wr_s          = chipselect && !write_n;
  assign ctrl_wr_s     = wr_s && (address == CSR_CTRL);
  assign period_wr_s   = wr_s && (address == CSR_PERIOD);
  assign pattern_wr_s  = wr_s && (address == CSR_PATTERN);
  assign load_value_s  = period_wr_s ? writedata[PERIOD_W-1:0] : period_r;
  assign enter_write_s = (state_r != ST_WRITE) && (state_s == ST_WRITE);
  assign unused_wdata_s = &{1'b0, writedata[31:PERIOD_W]};

  assign m_address    = PIO_ADDR;
  assign m_chipselect = m_chipselect_r;
  assign m_write_n    = m_write_n_r;
  assign m_writedata  = m_writedata_r;

  led_seq_prescaler #(
    .PERIOD_W   (PERIOD_W),
    .RESET_VALUE(DEFAULT_PERIOD)
  ) u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (reload_s),
    .load_value(load_value_s),
    .en        ((state_r == ST_RUN) && enable_r),
    .tick      (tick_s)
  );

  // FSM next state; WRITE has a strobe phase and a one-cycle release phase.
  always_comb begin
    state_s     = state_r;
    adv_s       = 1'b0;
    reload_s    = period_wr_s;
    xfer_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r) begin
          state_s = ST_WRITE;
        end else if (enable_r) begin
          state_s  = ST_RUN;
          reload_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pending_r) begin
          state_s = ST_WRITE;
        end else if (!enable_r) begin
          state_s = ST_IDLE;
        end else if (tick_s && (mode_r != MODE_STATIC)) begin
          state_s = ST_WRITE;
          adv_s   = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_WRITE: begin
        if (m_chipselect_r) begin
          xfer_done_s = !m_waitrequest;
          state_s     = ST_WRITE;
        end else if (enable_r) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Pattern datapath; a PATTERN write made after the master captured its data
  // is remembered in stale so it survives the completion of that transfer.
  always_comb begin
    step_s    = next_pattern(pattern_r, mode_r, dir_r);
    pattern_s = pattern_r;
    dir_s     = dir_r;
    if (pattern_wr_s) begin
      pattern_s = writedata[LED_W-1:0];
    end else if (adv_s) begin
      pattern_s = step_s.pattern;
      dir_s     = step_s.dir;
    end else begin
      pattern_s = pattern_r;
    end
    if (pattern_wr_s) begin
      pending_s = 1'b1;
    end else if (xfer_done_s) begin
      pending_s = stale_r;
    end else begin
      pending_s = pending_r;
    end
    if (xfer_done_s) begin
      stale_s = 1'b0;
    end else if (pattern_wr_s && (state_r == ST_WRITE) && m_chipselect_r) begin
      stale_s = 1'b1;
    end else begin
      stale_s = stale_r;
    end
  end

  // Control and configuration registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      enable_r  <= 1'b0;
      mode_r    <= MODE_STATIC;
      period_r  <= DEFAULT_PERIOD;
      pattern_r <= '0;
      dir_r     <= 1'b0;
      pending_r <= 1'b0;
      stale_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      pattern_r <= pattern_s;
      dir_r     <= dir_s;
      pending_r <= pending_s;
      stale_r   <= stale_s;
      if (ctrl_wr_s) begin
        enable_r <= writedata[0];
        mode_r   <= writedata[2:1];
      end
      if (period_wr_s) begin
        period_r <= writedata[PERIOD_W-1:0];
      end
    end
  end

  // Master port registers; data is latched once on WRITE entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_chipselect_r <= 1'b0;
      m_write_n_r    <= 1'b1;
      m_writedata_r  <= 32'h0;
    end else if (enter_write_s) begin
      m_chipselect_r <= 1'b1;
      m_write_n_r    <= 1'b0;
      m_writedata_r  <= {{(32-LED_W){1'b0}}, pattern_s};
    end else if (xfer_done_s) begin
      m_chipselect_r <= 1'b0;
      m_write_n_r    <= 1'b1;
    end else begin
      m_chipselect_r <= m_chipselect_r;
      m_write_n_r    <= m_write_n_r;
    end
  end

  // CSR read mux.
  always_comb begin
    readdata = 32'h0;
    case (address)
      CSR_CTRL:    readdata = {29'h0, mode_r, enable_r};
      CSR_PERIOD:  readdata = {{(32-PERIOD_W){1'b0}}, period_r};
      CSR_PATTERN: readdata = {{(32-LED_W){1'b0}}, pattern_r};
      CSR_STATUS:  readdata = {{(32-LED_W-3){1'b0}}, pending_r, dir_r,
                               (state_r == ST_WRITE), pattern_r};
      default:     readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: CSR vector table, directed corner sequences and
// randomized animation runs against a transaction-level pattern model.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, chipselect, write_n, m_chipselect, m_write_n, m_waitrequest;
  logic [1:0]  address, m_address;
  logic [31:0] writedata, readdata, m_writedata;

  led_pattern_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; logic [31:0] status; } xfer_t;
  xfer_t obs_q[$];

  // Completed master writes, seen mid-cycle.
  always @(negedge clk) begin
    if (reset_n && m_chipselect && !m_write_n && !m_waitrequest)
      obs_q.push_back('{m_writedata, cyc, readdata});
  end

  int checks = 0;
  int errors = 0;
  bit rand_wait = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_wait) m_waitrequest = 1'($urandom_range(0, 1));
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; address = CSR_STATUS;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = CSR_STATUS;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin step(); k++; end
    check({name, " transfer count reached"}, 32'(obs_q.size() >= n), 32'd1);
  endtask

  task automatic wait_cs(input int budget, input string name);
    int k = 0;
    while (m_chipselect !== 1'b1 && k < budget) begin step(); k++; end
    check({name, " chipselect seen"}, 32'(m_chipselect), 32'd1);
  endtask

  // Reference next-pattern rule written with plain integer arithmetic.
  function automatic int model_step(input int p, input int mode, inout int d);
    case (mode)
      1: return ((p * 2) + (p / 128)) % 256;
      2: begin
        if (d == 0) begin
          if (p >= 128) begin d = 1; return p / 2; end
          return (p * 2) % 256;
        end
        if (p % 2 == 1) begin d = 0; return (p * 2) % 256; end
        return p / 2;
      end
      3: return 255 - p;
      default: return p;
    endcase
  endfunction

  task automatic check_seq(input string name, input int seed, input int mode, input int n,
                           input bit chk_dir, inout int p, inout int d);
    p = seed;
    for (int i = 0; i < n; i++) begin
      if (i > 0) p = model_step(p, mode, d);
      if (i < obs_q.size()) begin
        check($sformatf("%s data[%0d]", name, i), obs_q[i].data, 32'(p));
        if (chk_dir) check($sformatf("%s dir[%0d]", name, i), 32'(obs_q[i].status[9]), 32'(d));
      end
    end
  endtask

  typedef struct { logic [1:0] addr; logic [31:0] wdata; logic [31:0] rexp; } csr_vec_t;
  csr_vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int p, d, mode, seed;
    reset_n = 1'b0; address = CSR_CTRL; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; m_waitrequest = 1'b0;
    vecs[0] = '{CSR_CTRL,    32'h0000_0006, 32'h0000_0006};
    vecs[1] = '{CSR_CTRL,    32'hFFFF_FFF8, 32'h0000_0000};
    vecs[2] = '{CSR_PERIOD,  32'hFFFF_FFFF, 32'h00FF_FFFF};
    vecs[3] = '{CSR_PERIOD,  32'h0000_0003, 32'h0000_0003};
    vecs[4] = '{CSR_PATTERN, 32'h0000_01A5, 32'h0000_00A5};
    vecs[5] = '{CSR_STATUS,  32'hFFFF_FFFF, 32'h0000_00A5};

    // Reset
    step(); step();
    reset_n = 1'b1;
    csr_read(CSR_CTRL, r);   check("reset ctrl", r, 32'h0);
    csr_read(CSR_PERIOD, r); check("reset period", r, 32'd12499999);
    csr_read(CSR_STATUS, r); check("reset status", r, 32'h0);
    check("reset m_chipselect", 32'(m_chipselect), 32'd0);
    check("reset m_write_n", 32'(m_write_n), 32'd1);
    check("reset m_writedata", m_writedata, 32'h0);
    check("reset m_address", 32'(m_address), 32'd0);

    // CSR table
    for (int i = 0; i < 6; i++) begin
      csr_write(vecs[i].addr, vecs[i].wdata);
      repeat (4) step();
      csr_read(vecs[i].addr, r);
      check($sformatf("csr vec %0d", i), r, vecs[i].rexp);
    end
    check("pattern write transfer count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) check("pattern write transfer data", obs_q[0].data, 32'hA5);
    obs_q.delete();

    // Rotate
    csr_write(CSR_PERIOD, 32'd3);
    csr_write(CSR_PATTERN, 32'h01);
    csr_write(CSR_CTRL, 32'h3);
    wait_xfers(10, 200, "rotate");
    csr_write(CSR_CTRL, 32'h0);
    repeat (10) step();
    d = 0;
    check_seq("rotate", 1, 1, 10, 1'b1, p, d);
    for (int i = 2; i < 10 && i < obs_q.size(); i++)
      check($sformatf("rotate spacing[%0d]", i), 32'(obs_q[i].cyc - obs_q[i-1].cyc), 32'd6);
    obs_q.delete();

    // Bounce
    csr_write(CSR_PERIOD, 32'd0);
    csr_write(CSR_PATTERN, 32'h40);
    csr_write(CSR_CTRL, 32'h5);
    wait_xfers(10, 200, "bounce");
    csr_write(CSR_CTRL, 32'h0);
    repeat (10) step();
    d = 0;
    check_seq("bounce", 32'h40, 2, 10, 1'b1, p, d);
    obs_q.delete();

    // Stalled write
    m_waitrequest = 1'b1;
    csr_write(CSR_PATTERN, 32'h55);
    wait_cs(20, "stall");
    for (int i = 0; i < 5; i++) begin
      check("stall m_chipselect", 32'(m_chipselect), 32'd1);
      check("stall m_write_n", 32'(m_write_n), 32'd0);
      check("stall m_address", 32'(m_address), 32'd0);
      check("stall m_writedata", m_writedata, 32'h55);
      csr_read(CSR_STATUS, r);
      check("stall busy", 32'(r[8]), 32'd1);
      step();
    end
    m_waitrequest = 1'b0;
    repeat (4) step();
    check("stall transfer count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) check("stall transfer data", obs_q[0].data, 32'h55);
    csr_read(CSR_STATUS, r);
    check("stall busy after", 32'(r[8]), 32'd0);
    obs_q.delete();

    // Pattern write collides with an in-flight transfer
    m_waitrequest = 1'b1;
    csr_write(CSR_PATTERN, 32'h0F);
    wait_cs(20, "collision");
    step();
    csr_write(CSR_PATTERN, 32'hAA);
    check("collision latched data", m_writedata, 32'h0F);
    csr_read(CSR_STATUS, r);
    check("collision status pattern", 32'(r[7:0]), 32'hAA);
    check("collision status pending", 32'(r[10]), 32'd1);
    m_waitrequest = 1'b0;
    wait_xfers(2, 20, "collision");
    repeat (4) step();
    if (obs_q.size() > 1) begin
      check("collision first data", obs_q[0].data, 32'h0F);
      check("collision second data", obs_q[1].data, 32'hAA);
    end
    check("collision transfer count", 32'(obs_q.size()), 32'd2);
    csr_read(CSR_STATUS, r);
    check("collision pending cleared", 32'(r[10]), 32'd0);
    obs_q.delete();

    // Disable during a stalled write
    csr_write(CSR_PERIOD, 32'd1000);
    csr_write(CSR_CTRL, 32'h3);
    m_waitrequest = 1'b1;
    csr_write(CSR_PATTERN, 32'h33);
    wait_cs(20, "disable");
    csr_write(CSR_CTRL, 32'h2);
    m_waitrequest = 1'b0;
    repeat (100) step();
    check("disable transfer count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) check("disable transfer data", obs_q[0].data, 32'h33);
    check("disable idle chipselect", 32'(m_chipselect), 32'd0);
    csr_read(CSR_STATUS, r);
    check("disable status", r, 32'h33);
    obs_q.delete();

    // Reset during a stalled write
    m_waitrequest = 1'b1;
    csr_write(CSR_PATTERN, 32'h77);
    wait_cs(20, "reset mid-write");
    reset_n = 1'b0;
    step();
    check("reset mid-write m_chipselect", 32'(m_chipselect), 32'd0);
    check("reset mid-write m_write_n", 32'(m_write_n), 32'd1);
    check("reset mid-write m_writedata", m_writedata, 32'h0);
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    csr_read(CSR_STATUS, r);
    check("reset mid-write status", r, 32'h0);
    obs_q.delete();

    // Randomized runs against the model
    d = 0;
    for (int rnd = 0; rnd < 6; rnd++) begin
      mode = (rnd == 0) ? 2 : int'($urandom_range(1, 3));
      seed = (rnd == 0) ? 0 : int'($urandom_range(0, 255));
      csr_write(CSR_CTRL, 32'(mode * 2));
      csr_write(CSR_PERIOD, 32'($urandom_range(0, 4)));
      csr_write(CSR_PATTERN, 32'(seed));
      rand_wait = 1'b1;
      csr_write(CSR_CTRL, 32'(mode * 2 + 1));
      wait_xfers(6, 400, $sformatf("random %0d", rnd));
      csr_write(CSR_CTRL, 32'h0);
      repeat (20) step();
      rand_wait = 1'b0;
      m_waitrequest = 1'b0;
      repeat (5) step();
      check_seq($sformatf("random %0d", rnd), seed, mode, obs_q.size(), 1'b0, p, d);
      csr_read(CSR_STATUS, r);
      check($sformatf("random %0d final status", rnd), r, 32'(p + d * 512));
      obs_q.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
